// File: rtl/dm_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dm_cache_pkg
//  Purpose  : Shared definitions for the direct-mapped write-through cache
//             controller: FSM state type, default geometry constants and
//             address-split helpers ({tag, index, offset}).
//  Revision : 1.0 - initial release
// ============================================================================
package dm_cache_pkg;

    localparam int c_ADDR_W   = 10;
    localparam int c_INDEX_W  = 5;
    localparam int c_OFFSET_W = 2;
    localparam int c_DATA_W   = 32;
    localparam int c_CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REFILL = 3'd1,
        ST_RDONE  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_WDONE  = 3'd4
    } state_t;

    // Helpers work on a zero-extended 32-bit address; callers size-cast the
    // result down to the field width they need.
    function automatic logic [31:0] get_tag(input logic [31:0] addr,
                                            input int index_w,
                                            input int offset_w);
        return addr >> (index_w + offset_w);
    endfunction

    function automatic logic [31:0] get_index(input logic [31:0] addr,
                                              input int index_w,
                                              input int offset_w);
        return (addr >> offset_w) & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] get_offset(input logic [31:0] addr,
                                               input int offset_w);
        return addr & ((32'd1 << offset_w) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_cache_data_ram.sv
`default_nettype none
// ============================================================================
//  Module   : dm_cache_data_ram
//  Purpose  : Cache data store, 2**AW words of DW bits. Synchronous write,
//             asynchronous (combinational) read so hits return in-cycle.
//  Ports    : clk          - write clock
//             we/waddr/wdata - write port
//             raddr/rdata  - asynchronous read port
//  Revision : 1.0 - initial release
// ============================================================================
module dm_cache_data_ram
    import dm_cache_pkg::*;
#(
    parameter int AW = c_INDEX_W + c_OFFSET_W,
    parameter int DW = c_DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/dm_cache_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module   : dm_cache_ctrl_param
//  Purpose  : Direct-mapped, write-through, no-write-allocate cache
//             controller between the core load/store stage and data memory.
//             Multi-word block refill over a ready-handshake port, core stall
//             on any miss or write, saturating hit/miss counters.
//  Ports    : clk, rst (async, active-high)
//             cpu_read/cpu_write/cpu_addr/cpu_wdata  - core request (held)
//             cpu_rdata/stall                        - core response
//             mem_read/mem_write/mem_addr/mem_wdata  - memory request
//             mem_rdata/mem_ready                    - memory response
//             hit_count/miss_count                   - profiling counters
//  Revision : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl_param
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W,
    parameter int INDEX_W  = c_INDEX_W,
    parameter int OFFSET_W = c_OFFSET_W,
    parameter int DATA_W   = c_DATA_W,
    parameter int CNT_W    = c_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES  = 2**INDEX_W;
    localparam int RAM_AW = INDEX_W + OFFSET_W;

    generate
        if (TAG_W < 1 || ADDR_W > 32) begin : g_bad_geometry
            $error("dm_cache_ctrl_param: TAG_W must be >= 1 and ADDR_W <= 32");
        end
    endgenerate

    state_t              r_state;
    state_t              w_next_state;
    logic [OFFSET_W-1:0] r_beat;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag_arr [LINES];
    logic [CNT_W-1:0]    r_hit_count;
    logic [CNT_W-1:0]    r_miss_count;

    // Request captured when it leaves IDLE, so an in-flight refill or write
    // keeps a stable address even if the core misbehaves and drops it.
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_wdata;

    logic [ADDR_W-1:0]   w_addr;
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_hit;

    logic                w_accept;
    logic                w_beat_clr;
    logic                w_beat_adv;
    logic                w_fill_done;
    logic                w_hit_inc;
    logic                w_miss_inc;
    logic                w_ram_we;
    logic [RAM_AW-1:0]   w_ram_waddr;
    logic [DATA_W-1:0]   w_ram_wdata;

    // In IDLE the live core address is decoded; in every other state the
    // captured one is, which also serves the RDONE read-out.
    assign w_addr   = (r_state == ST_IDLE) ? cpu_addr : r_req_addr;
    assign w_tag    = TAG_W'(get_tag(32'(w_addr), INDEX_W, OFFSET_W));
    assign w_index  = INDEX_W'(get_index(32'(w_addr), INDEX_W, OFFSET_W));
    assign w_offset = OFFSET_W'(get_offset(32'(w_addr), OFFSET_W));
    assign w_hit    = r_valid[w_index] && (r_tag_arr[w_index] == w_tag);

    dm_cache_data_ram #(
        .AW (RAM_AW),
        .DW (DATA_W)
    ) u_data_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (w_ram_waddr),
        .wdata (w_ram_wdata),
        .raddr ({w_index, w_offset}),
        .rdata (cpu_rdata)
    );

    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_accept     = 1'b0;
        w_beat_clr   = 1'b0;
        w_beat_adv   = 1'b0;
        w_fill_done  = 1'b0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_waddr  = {w_index, w_offset};
        w_ram_wdata  = r_req_wdata;

        case (r_state)
            ST_IDLE: begin
                // A write wins over a simultaneous read.
                if (cpu_write) begin
                    stall        = 1'b1;
                    w_accept     = 1'b1;
                    w_hit_inc    = w_hit;
                    w_miss_inc   = !w_hit;
                    w_next_state = ST_WRITE;
                end else if (cpu_read) begin
                    if (w_hit) begin
                        w_hit_inc = 1'b1;
                    end else begin
                        stall        = 1'b1;
                        w_accept     = 1'b1;
                        w_miss_inc   = 1'b1;
                        w_beat_clr   = 1'b1;
                        w_next_state = ST_REFILL;
                    end
                end
            end

            ST_REFILL: begin
                stall    = 1'b1;
                mem_read = 1'b1;
                mem_addr = {w_tag, w_index, r_beat};
                if (mem_ready) begin
                    w_ram_we    = 1'b1;
                    w_ram_waddr = {w_index, r_beat};
                    w_ram_wdata = mem_rdata;
                    w_beat_adv  = 1'b1;
                    // Valid only on the final beat: a reset mid-refill
                    // never leaves a half-filled line marked valid.
                    if (r_beat == {OFFSET_W{1'b1}}) begin
                        w_fill_done  = 1'b1;
                        w_next_state = ST_RDONE;
                    end
                end
            end

            ST_RDONE: begin
                w_next_state = ST_IDLE;
            end

            ST_WRITE: begin
                stall     = 1'b1;
                mem_write = 1'b1;
                mem_addr  = r_req_addr;
                mem_wdata = r_req_wdata;
                if (mem_ready) begin
                    w_ram_we     = w_hit;
                    w_next_state = ST_WDONE;
                end
            end

            // One unstalled cycle so the held store is not issued twice.
            ST_WDONE: begin
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_valid      <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_beat_clr) begin
                r_beat <= '0;
            end else if (w_beat_adv) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_fill_done) begin
                r_valid[w_index] <= 1'b1;
            end
            if (w_hit_inc && (r_hit_count != {CNT_W{1'b1}})) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            if (w_miss_inc && (r_miss_count != {CNT_W{1'b1}})) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    // Tag array and request capture carry no reset: they are only
    // meaningful behind a valid bit or an active transaction.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_req_addr  <= cpu_addr;
            r_req_wdata <= cpu_wdata;
        end
        if (w_fill_done) begin
            r_tag_arr[w_index] <= w_tag;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_cache_ctrl_param
//  Purpose  : Self-checking bench for dm_cache_ctrl_param. A bench-owned
//             memory answers the refill/write-through port with a
//             programmable ready delay; expectations come from directed
//             constants and a line-level cache model (valid/tag per line,
//             reference memory for data coherence).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dm_cache_ctrl_param;

    localparam int ADDR_W   = 10;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 5;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_read = 1'b0;
    logic              cpu_write = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              stall;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    dm_cache_ctrl_param #(
        .ADDR_W   (ADDR_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // ---------------- memory responder ----------------
    logic [DATA_W-1:0] mem     [1024];
    logic [DATA_W-1:0] ref_mem [1024];
    int mem_delay  = 0;
    int n_beats    = 0;
    int n_wacc     = 0;
    int n_wcyc     = 0;
    int n_unstable = 0;
    logic [ADDR_W-1:0] beat_log [$];

    initial begin : responder
        int wcnt;
        bit waiting;
        logic [ADDR_W-1:0] last_addr;
        wcnt = 0;
        waiting = 0;
        last_addr = '0;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                if (waiting && (mem_addr !== last_addr)) n_unstable++;
                if (mem_write) n_wcyc++;
                if (wcnt >= mem_delay) begin
                    mem_ready = 1'b1;
                    if (mem_read) begin
                        mem_rdata = mem[mem_addr];
                        n_beats++;
                        beat_log.push_back(mem_addr);
                    end else begin
                        mem[mem_addr] = mem_wdata;
                        mem_rdata = '0;
                        n_wacc++;
                    end
                    wcnt = 0;
                    waiting = 0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                    waiting = 1;
                    last_addr = mem_addr;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
                waiting = 0;
            end
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one held request starting at negedge+2; returns once the core
    // would have been released, with the traffic it caused.
    task automatic access(input logic rd, input logic wr,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                          input int dly,
                          output logic [DATA_W-1:0] rdata, output int stall_cyc,
                          output int rbeats, output int wacc, output int wcyc);
        int b0, w0, c0;
        bit done;
        b0 = n_beats;
        w0 = n_wacc;
        c0 = n_wcyc;
        mem_delay = dly;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = wd;
        stall_cyc = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (!stall) begin
                done = 1;
            end else begin
                stall_cyc++;
                @(negedge clk);
                #2;
            end
        end
        chk("access_completes", {63'd0, done}, 64'd1);
        rdata = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
        #2;
        rbeats = n_beats - b0;
        wacc   = n_wacc - w0;
        wcyc   = n_wcyc - c0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [DATA_W-1:0] rdat;
        int sc, rb, wa, wc, u0, b0;
        bit mvalid [32];
        int mtag   [32];
        int mhit, mmiss;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'h1000_0000 + i * 7;
            ref_mem[i] = 32'h1000_0000 + i * 7;
        end
        for (int i = 0; i < 4; i++) begin
            mem[10'h084 + i]     = 32'hA0 + i;
            ref_mem[10'h084 + i] = 32'hA0 + i;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
        chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_hit", 64'(hit_count), 64'd0);
        chk("rst_miss", 64'(miss_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #2;

        // Read miss 0x085, ready every cycle
        beat_log.delete();
        access(1, 0, 10'h085, '0, 0, rdat, sc, rb, wa, wc);
        chk("miss_rdata", 64'(rdat), 64'hA1);
        chk("miss_stall_cycles", 64'(sc), 64'd5);
        chk("miss_beats", 64'(rb), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("refill_addr", 64'(beat_log[i]), 64'(10'h084 + i));
        end
        chk("miss_count_1", 64'(miss_count), 64'd1);
        chk("hit_count_0", 64'(hit_count), 64'd0);

        // Read hit 0x087
        access(1, 0, 10'h087, '0, 0, rdat, sc, rb, wa, wc);
        chk("hit_rdata", 64'(rdat), 64'hA3);
        chk("hit_stall_cycles", 64'(sc), 64'd0);
        chk("hit_beats", 64'(rb), 64'd0);
        chk("hit_count_1", 64'(hit_count), 64'd1);

        // Write hit 0x086 with ready on the third write cycle
        u0 = n_unstable;
        access(0, 1, 10'h086, 32'hDEADBEEF, 2, rdat, sc, rb, wa, wc);
        ref_mem[10'h086] = 32'hDEADBEEF;
        chk("wr_cycles", 64'(wc), 64'd3);
        chk("wr_accepts", 64'(wa), 64'd1);
        chk("wr_stall_cycles", 64'(sc), 64'd4);
        chk("wr_addr_stable", 64'(n_unstable - u0), 64'd0);
        chk("wr_hit_count", 64'(hit_count), 64'd2);
        access(1, 0, 10'h086, '0, 0, rdat, sc, rb, wa, wc);
        chk("rd_after_wr_data", 64'(rdat), 64'hDEADBEEF);
        chk("rd_after_wr_traffic", 64'(rb + wa), 64'd0);
        chk("rd_after_wr_hit", 64'(hit_count), 64'd3);

        // Write miss 0x3F0: no allocate
        access(0, 1, 10'h3F0, 32'h12345678, 0, rdat, sc, rb, wa, wc);
        ref_mem[10'h3F0] = 32'h12345678;
        chk("wmiss_accepts", 64'(wa), 64'd1);
        chk("wmiss_beats", 64'(rb), 64'd0);
        chk("wmiss_count", 64'(miss_count), 64'd2);
        access(1, 0, 10'h3F0, '0, 0, rdat, sc, rb, wa, wc);
        chk("rd_after_wmiss_beats", 64'(rb), 64'd4);
        chk("rd_after_wmiss_data", 64'(rdat), 64'h12345678);
        chk("rd_after_wmiss_count", 64'(miss_count), 64'd3);

        // Reset in the middle of a refill of 0x100
        mem_delay = 0;
        cpu_read  = 1'b1;
        cpu_addr  = 10'h100;
        b0 = n_beats;
        for (int i = 0; i < 50 && (n_beats - b0) < 3; i++) begin
            @(negedge clk);
            #2;
        end
        rst = 1'b1;
        cpu_read = 1'b0;
        #1;
        chk("midrst_mem_read", {63'd0, mem_read}, 64'd0);
        chk("midrst_mem_write", {63'd0, mem_write}, 64'd0);
        chk("midrst_stall", {63'd0, stall}, 64'd0);
        chk("midrst_hit", 64'(hit_count), 64'd0);
        chk("midrst_miss", 64'(miss_count), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        access(1, 0, 10'h100, '0, 1, rdat, sc, rb, wa, wc);
        chk("post_rst_refill_beats", 64'(rb), 64'd4);
        chk("post_rst_refill_data", 64'(rdat), 64'(ref_mem[10'h100]));
        access(1, 0, 10'h085, '0, 0, rdat, sc, rb, wa, wc);
        chk("post_rst_old_line_miss", 64'(rb), 64'd4);
        chk("post_rst_miss_count", 64'(miss_count), 64'd2);

        // Counter saturation via write misses on an empty cache
        do_reset();
        for (int k = 0; k < 33; k++) begin
            access(0, 1, ADDR_W'(10'h200 + k), 32'hBEEF_0000 + k, 0, rdat, sc, rb, wa, wc);
            ref_mem[10'h200 + k] = 32'hBEEF_0000 + k;
            if (k == SAT - 1) chk("miss_reaches_max", 64'(miss_count), 64'(SAT));
        end
        chk("miss_saturated", 64'(miss_count), 64'(SAT));
        chk("hit_unchanged", 64'(hit_count), 64'd0);

        // Read and write together: treated as a write
        access(1, 0, 10'h200, '0, 0, rdat, sc, rb, wa, wc);
        chk("sat_refill_data", 64'(rdat), 64'hBEEF_0000);
        access(1, 1, 10'h201, 32'h5555AAAA, 1, rdat, sc, rb, wa, wc);
        ref_mem[10'h201] = 32'h5555AAAA;
        chk("both_no_refill", 64'(rb), 64'd0);
        chk("both_one_write", 64'(wa), 64'd1);
        chk("both_mem_updated", 64'(mem[10'h201]), 64'h5555AAAA);
        access(1, 0, 10'h201, '0, 0, rdat, sc, rb, wa, wc);
        chk("both_cache_updated", 64'(rdat), 64'h5555AAAA);
        chk("both_no_traffic", 64'(rb + wa), 64'd0);
        chk("both_hit_count", 64'(hit_count), 64'd2);

        // Randomised accesses against the line-level model
        do_reset();
        for (int i = 0; i < 32; i++) begin
            mvalid[i] = 0;
            mtag[i]   = 0;
        end
        mhit = 0;
        mmiss = 0;
        for (int k = 0; k < 120; k++) begin
            int op, t, idx, off, dly;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] wd;
            bit rd, wr, hexp;
            op  = int'($urandom_range(0, 9));
            t   = int'($urandom_range(0, 2));
            idx = int'($urandom_range(0, 5));
            off = int'($urandom_range(0, 3));
            dly = int'($urandom_range(0, 2));
            a   = ADDR_W'(t * 128 + idx * 4 + off);
            wd  = $urandom();
            rd  = (op <= 5) || (op == 9);
            wr  = (op >= 6);
            hexp = mvalid[idx] && (mtag[idx] == t);
            access(rd, wr, a, wd, dly, rdat, sc, rb, wa, wc);
            if (wr) begin
                chk("rnd_wr_accept", 64'(wa), 64'd1);
                chk("rnd_wr_no_refill", 64'(rb), 64'd0);
                ref_mem[a] = wd;
            end else begin
                chk("rnd_rd_beats", 64'(rb), hexp ? 64'd0 : 64'd4);
                chk("rnd_rd_data", 64'(rdat), 64'(ref_mem[a]));
                if (!hexp) begin
                    mvalid[idx] = 1;
                    mtag[idx]   = t;
                end
            end
            if (hexp) begin
                if (mhit < SAT) mhit++;
            end else begin
                if (mmiss < SAT) mmiss++;
            end
            chk("rnd_hit_count", 64'(hit_count), 64'(mhit));
            chk("rnd_miss_count", 64'(miss_count), 64'(mmiss));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
